mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of GRANT cycles allowed without m_ready before abort (range 2..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_req  input  1  instruction-fetch request, held until i_ack.
REQ-005 SHALL have port i_addr  input  32  fetch byte address.
REQ-006 SHALL have port i_ack  output  1  one-cycle pulse; i_rdata valid that cycle.
REQ-007 SHALL have port i_rdata  output  32  fetched word.
REQ-008 SHALL have ports d_req, d_we (input, 1 each) and d_addr, d_wdata (input, 32 each): data-stage request, write enable, address and store data.
REQ-009 SHALL have ports d_ack (output, 1) and d_rdata (output, 32): data-stage completion pulse and load data.
REQ-010 SHALL have ports m_req, m_we (output, 1 each) and m_addr, m_wdata (output, 32 each): shared memory port request, write enable, address and write data.
REQ-011 SHALL have ports m_ready (input, 1) and m_rdata (input, 32): memory completion and read data, sampled when m_ready=1.
REQ-012 SHALL have port i_stall  output  1  i_req & ~i_ack, for PC/IF_ID pause.
REQ-013 SHALL have port d_stall  output  1  d_req & ~d_ack, for pipeline pause.
REQ-014 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, GNT_I, GNT_D and RESP.
REQ-016 SHALL evaluate i_req/d_req only in IDLE; IDLE->GNT_D if d_req won, IDLE->GNT_I if i_req won, else stay in IDLE.
REQ-017 SHALL latch address, we (0 for fetch) and wdata of the winner on the IDLE->GNT transition; m_* outputs driven from these latches, so later requester changes are ignored.
REQ-018 SHALL assert m_req only in GNT_I/GNT_D.
REQ-019 SHALL, on m_ready=1 in GNT_x, capture m_rdata into x_rdata (reads only; d_rdata unchanged on writes) and go to RESP.
REQ-020 SHALL pulse x_ack for exactly the one RESP cycle, then return to IDLE; minimum latency req->ack is 2 cycles.
REQ-021 SHALL make a requester that holds req through ack start a new transaction from IDLE (back-to-back period 3 cycles with m_ready=1).
REQ-022 SHALL count GNT cycles with m_ready=0 using an 8-bit counter cleared on GNT entry; on reaching TIMEOUT, drop m_req, set err, go to RESP and pulse ack with rdata unchanged.
REQ-023 SHALL never assert i_ack and d_ack in the same cycle.
REQ-024 SHALL record last_grant (I or D) on every grant.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, force state=IDLE; m_req, m_we, i_ack, d_ack and err to 0; i_rdata, d_rdata, m_addr and m_wdata to 0; counter to 0; last_grant=I.
REQ-026 SHALL, when reset arrives mid-transaction, drop m_req in the next cycle and emit no ack for the aborted transaction.

Configuration
REQ-027 SHALL, with macro MEM_ARBITER_RR_EN defined, resolve simultaneous i_req/d_req to the requester opposite to last_grant (round-robin).
REQ-028 SHALL, without MEM_ARBITER_RR_EN, resolve simultaneous requests to data (fixed priority).

Verification
REQ-029 SHALL cover single fetch: i_req=1, i_addr=0x40, m_ready=1 in the first GNT cycle with m_rdata=0x2402000A -> m_req high one cycle, i_ack at cycle 2, i_rdata=0x2402000A.
REQ-030 SHALL cover store: d_req=1, d_we=1, d_addr=0x10, d_wdata=0x55, m_ready after 3 cycles -> m_we=1, m_addr=0x10, m_wdata=0x55 held for all GNT cycles; d_ack once; d_rdata unchanged.
REQ-031 SHALL cover a tie where i_req and d_req are both held for 4 transactions -> fixed priority: D,D,D,D while d_req is held; MEM_ARBITER_RR_EN: D,I,D,I.
REQ-032 SHALL cover timeout: TIMEOUT=4, m_ready tied to 0 -> m_req drops after 4 GNT cycles, err=1 and stays 1, ack pulses once.
REQ-033 SHALL cover reset mid-GNT_D: rst in the 2nd GNT cycle -> next cycle m_req=0, d_ack never asserts, all outputs at reset values.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) arbiter onto one shared memory port
//
// Optional feature macro: MEM_ARBITER_RR_EN
//   defined   : simultaneous i_req/d_req go to the requester opposite last_grant
//   undefined : simultaneous requests always go to the data side
//
// Parameters
//   TIMEOUT  max GRANT cycles without m_ready before the transfer is aborted (2..255)
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   i_req, i_addr                  fetch request (held until i_ack) and byte address
//   i_ack, i_rdata                 fetch completion pulse and fetched word
//   d_req, d_we, d_addr, d_wdata   data request, write enable, address, store data
//   d_ack, d_rdata                 data completion pulse and load data
//   m_req, m_we, m_addr, m_wdata   shared memory request and latched command
//   m_ready, m_rdata               memory completion and read data
//   i_stall, d_stall               pipeline pause (req & ~ack)
//   err                            sticky timeout flag
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        i_stall,
    output logic        d_stall,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Abort fires on the GRANT cycle where the miss counter already holds
    // TIMEOUT-1, so m_req is high for exactly TIMEOUT cycles.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       last_grant_d;   // 1: last grant went to data, 0: to fetch
    logic       pick_d;
    logic       in_gnt;
    logic       tmo_hit;
    logic       granting;

    assign in_gnt   = (state == GNT_I) || (state == GNT_D);
    assign tmo_hit  = in_gnt && !m_ready && (wait_cnt == TMO_LAST);
    assign granting = (state == IDLE) && (i_req || d_req);

    // Winner selection; only meaningful while in IDLE.
    always_comb begin
        pick_d = 1'b0;
`ifdef MEM_ARBITER_RR_EN
        pick_d = d_req && (!i_req || !last_grant_d);
`else
        pick_d = d_req;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    state_nxt = GNT_D;
                end else if (i_req) begin
                    state_nxt = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (m_ready || tmo_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        m_req = in_gnt;
        i_ack = (state == RESP) && !last_grant_d;
        d_ack = (state == RESP) && last_grant_d;
    end

    assign i_stall = i_req & ~i_ack;
    assign d_stall = d_req & ~d_ack;

    // Command latches, response capture, timeout counter and error flag.
    // The memory command is frozen at grant time so the requester may change
    // its inputs while the transfer is outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_we         <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            wait_cnt     <= '0;
            last_grant_d <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (granting) begin
                last_grant_d <= pick_d;
                wait_cnt     <= '0;
                if (pick_d) begin
                    m_addr  <= d_addr;
                    m_we    <= d_we;
                    m_wdata <= d_wdata;
                end else begin
                    m_addr  <= i_addr;
                    m_we    <= 1'b0;
                    m_wdata <= '0;
                end
            end else if (in_gnt && !m_ready && !tmo_hit) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if ((state == GNT_I) && m_ready) begin
                i_rdata <= m_rdata;
            end
            // Stores complete without touching the load-data register.
            if ((state == GNT_D) && m_ready && !m_we) begin
                d_rdata <= m_rdata;
            end
            if (tmo_hit) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        i_stall;
    logic        d_stall;
    logic        err;

    int n_pass = 0;
    int n_total = 0;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ack   (i_ack),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ready (m_ready),
        .m_rdata (m_rdata),
        .i_stall (i_stall),
        .d_stall (d_stall),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        m_ready;
        logic [31:0] m_rdata;
        logic        chk;
        logic        chk_bus;
        logic        e_m_req;
        logic        e_m_we;
        logic [31:0] e_m_addr;
        logic [31:0] e_m_wdata;
        logic        e_i_ack;
        logic        e_d_ack;
        logic [31:0] e_i_rdata;
        logic [31:0] e_d_rdata;
        logic        e_i_stall;
        logic        e_d_stall;
        logic        e_err;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_req"},   {31'd0, m_req},   32'd0);
        check({tag, "_m_we"},    {31'd0, m_we},    32'd0);
        check({tag, "_m_addr"},  m_addr,           32'd0);
        check({tag, "_m_wdata"}, m_wdata,          32'd0);
        check({tag, "_i_ack"},   {31'd0, i_ack},   32'd0);
        check({tag, "_d_ack"},   {31'd0, d_ack},   32'd0);
        check({tag, "_i_rdata"}, i_rdata,          32'd0);
        check({tag, "_d_rdata"}, d_rdata,          32'd0);
        check({tag, "_err"},     {31'd0, err},     32'd0);
    endtask

    initial begin
        int     hi_cnt;
        int     ack_cnt;
        logic [31:0] ack_rdata;
        logic   ack_err;
        int     n_gnt;
        logic   exp_d [4];
        logic   got_d [4];
        logic [31:0] gnt_addr [4];
        logic [31:0] cur_addr;
        int     both_seen;

        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; m_ready = 1'b0; m_rdata = '0;

        //            rst  ireq iaddr   dreq dwe daddr   dwdata  mrdy mrdata        chk bus mreq mwe maddr   mwdata  iack dack irdata        drdata        istl dstl err
        vt[0]  = '{1'b1,1'b0,32'h00,1'b0,1'b0,32'h00,32'h00,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h00,32'h00,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,1'b0};
        vt[1]  = '{1'b1,1'b0,32'h00,1'b0,1'b0,32'h00,32'h00,1'b0,32'h0,        1'b1,1'b1,1'b0,1'b0,32'h00,32'h00,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,1'b0};
        vt[2]  = '{1'b0,1'b0,32'h00,1'b0,1'b0,32'h00,32'h00,1'b0,32'h0,        1'b1,1'b1,1'b0,1'b0,32'h00,32'h00,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,1'b0};
        vt[3]  = '{1'b0,1'b1,32'h40,1'b0,1'b0,32'h00,32'h00,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h00,32'h00,1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,1'b0};
        vt[4]  = '{1'b0,1'b1,32'h40,1'b0,1'b0,32'h00,32'h00,1'b1,32'h2402000A,1'b1,1'b1,1'b1,1'b0,32'h40,32'h00,1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,1'b0};
        vt[5]  = '{1'b0,1'b1,32'h40,1'b0,1'b0,32'h00,32'h00,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h00,32'h00,1'b1,1'b0,32'h2402000A,32'h0,        1'b0,1'b0,1'b0};
        vt[6]  = '{1'b0,1'b0,32'h00,1'b0,1'b0,32'h00,32'h00,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h00,32'h00,1'b0,1'b0,32'h2402000A,32'h0,        1'b0,1'b0,1'b0};
        vt[7]  = '{1'b0,1'b0,32'h00,1'b1,1'b1,32'h10,32'h55,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h00,32'h00,1'b0,1'b0,32'h2402000A,32'h0,        1'b0,1'b1,1'b0};
        vt[8]  = '{1'b0,1'b0,32'h00,1'b1,1'b1,32'h99,32'hAA,1'b0,32'hDEAD,     1'b1,1'b1,1'b1,1'b1,32'h10,32'h55,1'b0,1'b0,32'h2402000A,32'h0,        1'b0,1'b1,1'b0};
        vt[9]  = '{1'b0,1'b0,32'h00,1'b1,1'b1,32'h99,32'hAA,1'b0,32'hDEAD,     1'b1,1'b1,1'b1,1'b1,32'h10,32'h55,1'b0,1'b0,32'h2402000A,32'h0,        1'b0,1'b1,1'b0};
        vt[10] = '{1'b0,1'b0,32'h00,1'b1,1'b1,32'h99,32'hAA,1'b1,32'hBEEF,     1'b1,1'b1,1'b1,1'b1,32'h10,32'h55,1'b0,1'b0,32'h2402000A,32'h0,        1'b0,1'b1,1'b0};
        vt[11] = '{1'b0,1'b0,32'h00,1'b1,1'b1,32'h10,32'h55,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h00,32'h00,1'b0,1'b1,32'h2402000A,32'h0,        1'b0,1'b0,1'b0};
        vt[12] = '{1'b0,1'b0,32'h00,1'b0,1'b0,32'h00,32'h00,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h00,32'h00,1'b0,1'b0,32'h2402000A,32'h0,        1'b0,1'b0,1'b0};
        vt[13] = '{1'b0,1'b0,32'h00,1'b1,1'b0,32'h20,32'h00,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h00,32'h00,1'b0,1'b0,32'h2402000A,32'h0,        1'b0,1'b1,1'b0};
        vt[14] = '{1'b0,1'b0,32'h00,1'b1,1'b0,32'h20,32'h00,1'b1,32'h12345678,1'b1,1'b1,1'b1,1'b0,32'h20,32'h00,1'b0,1'b0,32'h2402000A,32'h0,        1'b0,1'b1,1'b0};
        vt[15] = '{1'b0,1'b0,32'h00,1'b1,1'b0,32'h20,32'h00,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h00,32'h00,1'b0,1'b1,32'h2402000A,32'h12345678,1'b0,1'b0,1'b0};
        vt[16] = '{1'b0,1'b0,32'h00,1'b0,1'b0,32'h00,32'h00,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h00,32'h00,1'b0,1'b0,32'h2402000A,32'h12345678,1'b0,1'b0,1'b0};

        // Each row: drive inputs after the falling edge, compare the current
        // cycle's outputs, then let the next rising edge consume the inputs.
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            rst = vt[k].rst; i_req = vt[k].i_req; i_addr = vt[k].i_addr;
            d_req = vt[k].d_req; d_we = vt[k].d_we; d_addr = vt[k].d_addr;
            d_wdata = vt[k].d_wdata; m_ready = vt[k].m_ready; m_rdata = vt[k].m_rdata;
            #1;
            if (vt[k].chk) begin
                check($sformatf("r%0d_m_req", k),   {31'd0, m_req},   {31'd0, vt[k].e_m_req});
                check($sformatf("r%0d_i_ack", k),   {31'd0, i_ack},   {31'd0, vt[k].e_i_ack});
                check($sformatf("r%0d_d_ack", k),   {31'd0, d_ack},   {31'd0, vt[k].e_d_ack});
                check($sformatf("r%0d_i_rdata", k), i_rdata,          vt[k].e_i_rdata);
                check($sformatf("r%0d_d_rdata", k), d_rdata,          vt[k].e_d_rdata);
                check($sformatf("r%0d_i_stall", k), {31'd0, i_stall}, {31'd0, vt[k].e_i_stall});
                check($sformatf("r%0d_d_stall", k), {31'd0, d_stall}, {31'd0, vt[k].e_d_stall});
                check($sformatf("r%0d_err", k),     {31'd0, err},     {31'd0, vt[k].e_err});
                if (vt[k].chk_bus) begin
                    check($sformatf("r%0d_m_we", k),   {31'd0, m_we}, {31'd0, vt[k].e_m_we});
                    check($sformatf("r%0d_m_addr", k), m_addr,        vt[k].e_m_addr);
                    if (vt[k].e_m_we || vt[k].rst) begin
                        check($sformatf("r%0d_m_wdata", k), m_wdata, vt[k].e_m_wdata);
                    end
                end
            end
        end

        // Timeout: load with m_ready stuck low; d_rdata keeps the last load value.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30; m_ready = 1'b0; m_rdata = 32'hFFFF0000;
        #1;
        check("tmo_idle_m_req", {31'd0, m_req}, 32'd0);
        hi_cnt = 0; ack_cnt = 0; ack_rdata = '0; ack_err = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (m_req) hi_cnt++;
            if (d_ack) begin
                ack_cnt++;
                ack_rdata = d_rdata;
                ack_err = err;
                d_req = 1'b0;
            end
        end
        check("tmo_m_req_cycles", hi_cnt, 32'd4);
        check("tmo_ack_count", ack_cnt, 32'd1);
        check("tmo_rdata_kept", ack_rdata, 32'h12345678);
        check("tmo_err_at_ack", {31'd0, ack_err}, 32'd1);
        check("tmo_err_sticky", {31'd0, err}, 32'd1);

        // Tie: both requesters held from a fresh reset (last_grant = I).
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("rst2");
        rst = 1'b0;
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        m_ready = 1'b1; m_rdata = 32'hA5A5A5A5;
`ifdef MEM_ARBITER_RR_EN
        exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
`else
        exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1; exp_d[3] = 1'b1;
`endif
        n_gnt = 0; both_seen = 0; cur_addr = '0;
        for (int g = 0; g < 4; g++) begin
            got_d[g] = 1'b0;
            gnt_addr[g] = '0;
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            if (m_req) cur_addr = m_addr;
            if (i_ack && d_ack) both_seen++;
            if ((i_ack || d_ack) && n_gnt < 4) begin
                got_d[n_gnt] = d_ack;
                gnt_addr[n_gnt] = cur_addr;
                n_gnt++;
                if (n_gnt == 4) begin
                    i_req = 1'b0;
                    d_req = 1'b0;
                    break;
                end
            end
        end
        check("tie_grant_count", n_gnt, 32'd4);
        check("tie_no_double_ack", both_seen, 32'd0);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("tie_winner%0d", g), {31'd0, got_d[g]}, {31'd0, exp_d[g]});
            check($sformatf("tie_addr%0d", g), gnt_addr[g], exp_d[g] ? 32'h200 : 32'h100);
        end

        // Reset arriving in the second GRANT cycle of a store.
        @(negedge clk);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h77; m_ready = 1'b0;
        #1;
        check("rstmid_idle_m_req", {31'd0, m_req}, 32'd0);
        @(negedge clk);
        #1;
        check("rstmid_gnt1_m_req", {31'd0, m_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_gnt2_m_req", {31'd0, m_req}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        d_req = 1'b0; d_we = 1'b0;
        #1;
        check_reset_outputs("rstmid");
        check("rstmid_d_stall", {31'd0, d_stall}, 32'd0);
        ack_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (d_ack) ack_cnt++;
        end
        check("rstmid_no_ack", ack_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
